// File: rtl/neander_xp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neander_xp_pkg
//  Description : Shared selector encodings for the NEANDER-X datapath: ALU
//                operation, AC source and REM address source, plus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package neander_xp_pkg;

    localparam int ALU_OP_W   = 3;
    localparam int AC_SRC_W   = 3;
    localparam int ADDR_SEL_W = 2;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD   = 3'd0,
        ALU_AND   = 3'd1,
        ALU_OR    = 3'd2,
        ALU_NOT   = 3'd3,
        ALU_SUB   = 3'd4,
        ALU_SHL   = 3'd5,
        ALU_SHR   = 3'd6,
        ALU_PASSB = 3'd7
    } alu_op_e;

    typedef enum logic [AC_SRC_W-1:0] {
        AC_ALU       = 3'd0,
        AC_MEM       = 3'd1,
        AC_IO_IN     = 3'd2,
        AC_IO_STATUS = 3'd3,
        AC_X         = 3'd4,
        AC_MUL_LO    = 3'd5,
        AC_MUL_HI    = 3'd6,
        AC_ZERO      = 3'd7
    } ac_src_e;

    typedef enum logic [ADDR_SEL_W-1:0] {
        ADDR_PC  = 2'd0,
        ADDR_RDM = 2'd1,
        ADDR_SP  = 2'd2,
        ADDR_IDX = 2'd3
    } addr_sel_e;

endpackage
`default_nettype wire

// File: rtl/neander_xp_datapath_if.sv
`default_nettype none
// ============================================================================
//  Module      : neander_xp_datapath_if
//  Description : Memory and I/O bus between the datapath (master) and the
//                external RAM / I/O block (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface neander_xp_datapath_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] io_in;
    logic [DATA_W-1:0] io_status;
    logic [DATA_W-1:0] io_out;

    modport master (
        output mem_addr, mem_wdata, io_out,
        input  mem_rdata, io_in, io_status
    );

    modport slave (
        input  mem_addr, mem_wdata, io_out,
        output mem_rdata, io_in, io_status
    );
endinterface
`default_nettype wire

// File: rtl/neander_xp_mul.sv
`default_nettype none
// ============================================================================
//  Module      : neander_xp_mul
//  Description : Unsigned shift-add multiplier, one multiplier bit per cycle.
//                Product is only published when the last step completes.
//                Instantiated by the datapath when NEANDER_XP_MUL_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module neander_xp_mul #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    output logic                  busy,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0]   mcand;
    logic [2*DATA_W-1:0] acc;      // {partial high half, remaining multiplier bits}
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W:0]     partial;
    logic [2*DATA_W-1:0] acc_next;

    // One shift-add step: add multiplicand into the high half if LSB set, shift right
    always_comb begin
        partial  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, mcand} : '0);
        acc_next = {partial, acc[DATA_W-1:1]};
    end

    // Iteration control; a start while busy is ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (busy) begin
                acc <= acc_next;
                cnt <= cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W-1)) begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    product <= acc_next;
                end
            end else if (start) begin
                busy  <= 1'b1;
                cnt   <= '0;
                mcand <= a;
                acc   <= {{DATA_W{1'b0}}, b};
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/neander_xp_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : neander_xp_datapath
//  Description : NEANDER-X datapath: PC/REM/RDM/RI/AC/X/SP registers, inline
//                ALU with carry, NZC flags, stack and indexed addressing,
//                latched output port. Optional iterative multiplier enabled by
//                defining NEANDER_XP_MUL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module neander_xp_datapath
    import neander_xp_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 8,
    parameter logic [ADDR_W-1:0] STACK_TOP = '1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pc_inc,
    input  logic                  pc_load,
    input  logic                  ac_load,
    input  logic                  x_load,
    input  logic                  ri_load,
    input  logic                  rem_load,
    input  logic                  rdm_load,
    input  logic                  nz_load,
    input  logic                  c_load,
    input  logic                  sp_inc,
    input  logic                  sp_dec,
    input  logic                  io_write,
    input  logic [ADDR_SEL_W-1:0] addr_sel,
    input  logic                  wdata_sel,
    input  logic [AC_SRC_W-1:0]   ac_src,
    input  logic [ALU_OP_W-1:0]   alu_op,
    input  logic                  mul_start,
    neander_xp_datapath_if.master bus,
    output logic [3:0]            opcode,
    output logic                  flag_n,
    output logic                  flag_z,
    output logic                  flag_c,
    output logic                  mul_busy,
    output logic                  mul_done,
    output logic [ADDR_W-1:0]     dbg_pc,
    output logic [ADDR_W-1:0]     dbg_sp,
    output logic [DATA_W-1:0]     dbg_ac,
    output logic [DATA_W-1:0]     dbg_x
);
    logic [ADDR_W-1:0] pc, rem, sp, rem_in;
    logic [DATA_W-1:0] rdm, ri, ac, x, io_out_r;
    logic [DATA_W-1:0] alu_res, ac_in, mul_lo, mul_hi;
    logic              alu_c;
    logic              unused_ri;

    assign bus.mem_addr  = rem;
    assign bus.mem_wdata = wdata_sel ? DATA_W'(pc) : ac;
    assign bus.io_out    = io_out_r;
    assign opcode        = ri[DATA_W-1 -: 4];
    assign dbg_pc        = pc;
    assign dbg_sp        = sp;
    assign dbg_ac        = ac;
    assign dbg_x         = x;
    assign unused_ri     = ^ri;   // only the opcode nibble leaves the block

`ifdef NEANDER_XP_MUL_EN
    logic [2*DATA_W-1:0] product;

    neander_xp_mul #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .a       (ac),
        .b       (bus.mem_rdata),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
    );
    assign mul_lo = product[DATA_W-1:0];
    assign mul_hi = product[2*DATA_W-1:DATA_W];
`else
    logic mul_done_r;

    // Without a multiplier, acknowledge a start immediately so the control unit never stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mul_done_r <= 1'b0;
        else       mul_done_r <= mul_start;
    end
    assign mul_busy = 1'b0;
    assign mul_done = mul_done_r;
    assign mul_lo   = '0;
    assign mul_hi   = '0;
`endif

    // ALU: a = AC, b = memory data; logic ops keep the existing carry
    always_comb begin
        alu_res = ac;
        alu_c   = flag_c;
        case (alu_op_e'(alu_op))
            ALU_ADD:   {alu_c, alu_res} = {1'b0, ac} + {1'b0, bus.mem_rdata};
            ALU_SUB:   {alu_c, alu_res} = {1'b0, ac} - {1'b0, bus.mem_rdata};
            ALU_AND:   alu_res = ac & bus.mem_rdata;
            ALU_OR:    alu_res = ac | bus.mem_rdata;
            ALU_NOT:   alu_res = ~ac;
            ALU_SHL:   {alu_c, alu_res} = {ac, 1'b0};
            ALU_SHR:   {alu_res, alu_c} = {1'b0, ac};
            ALU_PASSB: alu_res = bus.mem_rdata;
            default:   alu_res = ac;
        endcase
    end

    // AC input mux, also the source for N/Z
    always_comb begin
        ac_in = '0;
        case (ac_src_e'(ac_src))
            AC_ALU:       ac_in = alu_res;
            AC_MEM:       ac_in = bus.mem_rdata;
            AC_IO_IN:     ac_in = bus.io_in;
            AC_IO_STATUS: ac_in = bus.io_status;
            AC_X:         ac_in = x;
            AC_MUL_LO:    ac_in = mul_lo;
            AC_MUL_HI:    ac_in = mul_hi;
            default:      ac_in = '0;
        endcase
    end

    // REM source mux; indexed address wraps within the address width
    always_comb begin
        rem_in = pc;
        case (addr_sel_e'(addr_sel))
            ADDR_PC:  rem_in = pc;
            ADDR_RDM: rem_in = rdm[ADDR_W-1:0];
            ADDR_SP:  rem_in = sp;
            ADDR_IDX: rem_in = rdm[ADDR_W-1:0] + x[ADDR_W-1:0];
            default:  rem_in = pc;
        endcase
    end

    // Program counter: a jump load takes priority over increment
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        pc <= '0;
        else if (pc_load) pc <= rdm[ADDR_W-1:0];
        else if (pc_inc)  pc <= pc + ADDR_W'(1);
    end

    // Stack pointer: simultaneous push/pop cancels out
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sp <= STACK_TOP;
        else begin
            case ({sp_inc, sp_dec})
                2'b10:   sp <= sp + ADDR_W'(1);
                2'b01:   sp <= sp - ADDR_W'(1);
                default: sp <= sp;
            endcase
        end
    end

    // Memory interface and instruction registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem <= '0;
            rdm <= '0;
            ri  <= '0;
        end else begin
            if (rem_load) rem <= rem_in;
            if (rdm_load) rdm <= bus.mem_rdata;
            if (ri_load)  ri  <= rdm;
        end
    end

    // Accumulator, index register and output port latch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac       <= '0;
            x        <= '0;
            io_out_r <= '0;
        end else begin
            if (ac_load)  ac       <= ac_in;
            if (x_load)   x        <= ac;
            if (io_write) io_out_r <= ac;
        end
    end

    // Flags: N/Z follow the AC input mux, C follows the ALU, on separate strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_c <= 1'b0;
        end else begin
            if (nz_load) begin
                flag_n <= ac_in[DATA_W-1];
                flag_z <= (ac_in == '0);
            end
            if (c_load) flag_c <= alu_c;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_neander_xp_datapath.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neander_xp_datapath
//  Description : Self-checking bench for neander_xp_datapath: ALU vector
//                table, randomized ALU/stack/indexing against an arithmetic
//                reference, and hand sequences for multiplier timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neander_xp_datapath;
    import neander_xp_pkg::*;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int MODV = 1 << DW;

    logic          clk = 1'b0;
    logic          reset;
    logic          pc_inc, pc_load, ac_load, x_load, ri_load, rem_load, rdm_load;
    logic          nz_load, c_load, sp_inc, sp_dec, io_write, mul_start;
    logic [1:0]    addr_sel;
    logic          wdata_sel;
    logic [2:0]    ac_src;
    logic [2:0]    alu_op;
    logic [3:0]    opcode;
    logic          flag_n, flag_z, flag_c, mul_busy, mul_done;
    logic [AW-1:0] dbg_pc, dbg_sp;
    logic [DW-1:0] dbg_ac, dbg_x;

    int checks = 0;
    int errors = 0;

    neander_xp_datapath_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    neander_xp_datapath #(.DATA_W(DW), .ADDR_W(AW), .STACK_TOP(8'hF0)) dut (
        .clk(clk), .reset(reset),
        .pc_inc(pc_inc), .pc_load(pc_load), .ac_load(ac_load), .x_load(x_load),
        .ri_load(ri_load), .rem_load(rem_load), .rdm_load(rdm_load),
        .nz_load(nz_load), .c_load(c_load), .sp_inc(sp_inc), .sp_dec(sp_dec),
        .io_write(io_write), .addr_sel(addr_sel), .wdata_sel(wdata_sel),
        .ac_src(ac_src), .alu_op(alu_op), .mul_start(mul_start), .bus(bus),
        .opcode(opcode), .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c),
        .mul_busy(mul_busy), .mul_done(mul_done),
        .dbg_pc(dbg_pc), .dbg_sp(dbg_sp), .dbg_ac(dbg_ac), .dbg_x(dbg_x)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    op;
        logic [DW-1:0] a, b;
        logic          c0;
        logic [DW-1:0] e_ac;
        logic          e_n, e_z, e_c;
    } vec_t;

    vec_t vt[14];

    task automatic clear_strobes();
        {pc_inc, pc_load, ac_load, x_load, ri_load, rem_load, rdm_load} = '0;
        {nz_load, c_load, sp_inc, sp_dec, io_write, mul_start} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        clear_strobes();
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_ac(input logic [DW-1:0] v);
        bus.mem_rdata = v; ac_src = AC_MEM; ac_load = 1'b1; tick();
    endtask

    task automatic load_rdm(input logic [DW-1:0] v);
        bus.mem_rdata = v; rdm_load = 1'b1; tick();
    endtask

    task automatic load_x(input logic [DW-1:0] v);
        load_ac(v); x_load = 1'b1; tick();
    endtask

    task automatic read_src(input logic [2:0] src, output logic [DW-1:0] v);
        ac_src = src; ac_load = 1'b1; tick(); v = dbg_ac;
    endtask

    // Force the carry to c0 without touching AC (a is the current AC value)
    task automatic set_c(input logic [DW-1:0] a, input logic c0);
        if (!c0) begin alu_op = ALU_SUB; bus.mem_rdata = '0; end
        else if (a != 0) begin alu_op = ALU_ADD; bus.mem_rdata = '1; end
        else begin alu_op = ALU_SUB; bus.mem_rdata = 8'h01; end
        c_load = 1'b1; tick();
    endtask

    task automatic run_alu(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic c0);
        load_ac(a);
        set_c(a, c0);
        alu_op = op; bus.mem_rdata = b; ac_src = AC_ALU;
        ac_load = 1'b1; nz_load = 1'b1; c_load = 1'b1;
        tick();
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 4*DW; n++) begin
            if (mul_done) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    // Reference ALU from the arithmetic definition of each operation
    function automatic void alu_ref(input int op, input int a, input int b, input int cin,
                                    output int res, output int cout);
        res = a; cout = cin;
        case (op)
            0: begin res = (a + b) % MODV; cout = (a + b >= MODV) ? 1 : 0; end
            1: res = a & b;
            2: res = a | b;
            3: res = (MODV - 1) - a;
            4: begin res = (a - b + MODV) % MODV; cout = (a < b) ? 1 : 0; end
            5: begin res = (a * 2) % MODV; cout = (a >= MODV / 2) ? 1 : 0; end
            6: begin res = a / 2; cout = a % 2; end
            default: res = b;
        endcase
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] v;
        int            sp_m, res, cout, a, b, c0, op;
        bit            ok;

        vt[0]  = '{ALU_ADD,   8'hF0, 8'h20, 1'b0, 8'h10, 1'b0, 1'b0, 1'b1};
        vt[1]  = '{ALU_SUB,   8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{ALU_ADD,   8'h7F, 8'h01, 1'b0, 8'h80, 1'b1, 1'b0, 1'b0};
        vt[3]  = '{ALU_SUB,   8'h55, 8'h55, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[4]  = '{ALU_AND,   8'hF0, 8'h3C, 1'b1, 8'h30, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{ALU_OR,    8'h0F, 8'hF0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{ALU_NOT,   8'h5A, 8'h00, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{ALU_SHL,   8'h81, 8'h00, 1'b0, 8'h02, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{ALU_SHR,   8'h81, 8'h00, 1'b0, 8'h40, 1'b0, 1'b0, 1'b1};
        vt[9]  = '{ALU_SHR,   8'h02, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        vt[10] = '{ALU_PASSB, 8'h77, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vt[11] = '{ALU_ADD,   8'hFF, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vt[12] = '{ALU_PASSB, 8'h00, 8'hC3, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b1};
        vt[13] = '{ALU_SHL,   8'h40, 8'h00, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

        clear_strobes();
        addr_sel = ADDR_PC; wdata_sel = 1'b0; ac_src = AC_ALU; alu_op = ALU_ADD;
        bus.mem_rdata = '0; bus.io_in = '0; bus.io_status = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk("reset_sp", dbg_sp, 8'hF0);
        chk("reset_pc", dbg_pc, 0);
        chk("reset_ac", dbg_ac, 0);
        chk("reset_x", dbg_x, 0);
        chk("reset_mem_addr", bus.mem_addr, 0);
        chk("reset_mem_wdata", bus.mem_wdata, 0);
        chk("reset_io_out", bus.io_out, 0);
        chk("reset_opcode", opcode, 0);
        chk("reset_flags", {flag_n, flag_z, flag_c}, 3'b000);
        chk("reset_mul", {mul_busy, mul_done}, 2'b00);

        // ALU vector table
        foreach (vt[i]) begin
            run_alu(vt[i].op, vt[i].a, vt[i].b, vt[i].c0);
            chk($sformatf("vec%0d_ac", i), dbg_ac, vt[i].e_ac);
            chk($sformatf("vec%0d_n", i), flag_n, vt[i].e_n);
            chk($sformatf("vec%0d_z", i), flag_z, vt[i].e_z);
            chk($sformatf("vec%0d_c", i), flag_c, vt[i].e_c);
        end

        // Randomized ALU against the arithmetic reference
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 7));
            a  = int'($urandom_range(0, MODV - 1));
            b  = int'($urandom_range(0, MODV - 1));
            c0 = int'($urandom_range(0, 1));
            alu_ref(op, a, b, c0, res, cout);
            run_alu(3'(op), DW'(a), DW'(b), c0[0]);
            chk($sformatf("rnd_alu%0d_op%0d_ac", i, op), dbg_ac, res);
            chk($sformatf("rnd_alu%0d_op%0d_c", i, op), flag_c, cout);
            chk($sformatf("rnd_alu%0d_nz", i), {flag_n, flag_z},
                {res >= MODV / 2 ? 1'b1 : 1'b0, res == 0 ? 1'b1 : 1'b0});
        end

        // Stack pointer: wrap up to zero, wrap down, cancel, REM sees old SP
        repeat (16) begin sp_inc = 1'b1; tick(); end
        chk("sp_wrap_up", dbg_sp, 8'h00);
        sp_dec = 1'b1; tick();
        chk("sp_wrap_down", dbg_sp, 8'hFF);
        sp_inc = 1'b1; sp_dec = 1'b1; tick();
        chk("sp_both", dbg_sp, 8'hFF);
        addr_sel = ADDR_SP; rem_load = 1'b1; sp_dec = 1'b1; tick();
        chk("rem_old_sp", bus.mem_addr, 8'hFF);
        chk("sp_after_push", dbg_sp, 8'hFE);
        sp_m = 8'hFE;
        for (int i = 0; i < 60; i++) begin
            int r;
            bit rl;
            r  = int'($urandom_range(0, 3));
            rl = 1'($urandom_range(0, 1));
            sp_inc = r[1]; sp_dec = r[0]; rem_load = rl; addr_sel = ADDR_SP;
            tick();
            if (rl) chk($sformatf("rnd_sp%0d_rem", i), bus.mem_addr, sp_m);
            if (r == 2) sp_m = (sp_m + 1) % MODV;
            else if (r == 1) sp_m = (sp_m + MODV - 1) % MODV;
            chk($sformatf("rnd_sp%0d", i), dbg_sp, sp_m);
        end

        // Indexed addressing
        load_x(8'h05); load_rdm(8'hFE);
        addr_sel = ADDR_IDX; rem_load = 1'b1; tick();
        chk("idx_wrap", bus.mem_addr, 8'h03);
        for (int i = 0; i < 10; i++) begin
            a = int'($urandom_range(0, MODV - 1));
            b = int'($urandom_range(0, MODV - 1));
            load_x(DW'(a)); load_rdm(DW'(b));
            addr_sel = ADDR_IDX; rem_load = 1'b1; tick();
            chk($sformatf("rnd_idx%0d", i), bus.mem_addr, (a + b) % MODV);
        end
        load_rdm(8'h9C); addr_sel = ADDR_RDM; rem_load = 1'b1; tick();
        chk("rem_from_rdm", bus.mem_addr, 8'h9C);

        // PC increment, load priority, wrap, write-data select
        repeat (3) begin pc_inc = 1'b1; tick(); end
        chk("pc_inc", dbg_pc, 3);
        addr_sel = ADDR_PC; rem_load = 1'b1; tick();
        chk("rem_from_pc", bus.mem_addr, 3);
        load_rdm(8'h42); pc_load = 1'b1; pc_inc = 1'b1; tick();
        chk("pc_load_priority", dbg_pc, 8'h42);
        load_ac(8'h3B);
        wdata_sel = 1'b1; #1;
        chk("wdata_pc", bus.mem_wdata, 8'h42);
        wdata_sel = 1'b0; #1;
        chk("wdata_ac", bus.mem_wdata, 8'h3B);
        load_rdm(8'hFF); pc_load = 1'b1; tick();
        pc_inc = 1'b1; tick();
        chk("pc_wrap", dbg_pc, 0);

        // Instruction register and output port
        load_rdm(8'hA7); ri_load = 1'b1; tick();
        chk("opcode", opcode, 4'hA);
        load_ac(8'h5C); io_write = 1'b1; tick();
        chk("io_out_write", bus.io_out, 8'h5C);
        load_ac(8'h00);
        chk("io_out_hold", bus.io_out, 8'h5C);

        // AC sources and flag independence
        bus.io_in = 8'h33; read_src(AC_IO_IN, v);
        chk("ac_io_in", v, 8'h33);
        bus.io_status = 8'h81; read_src(AC_IO_STATUS, v);
        chk("ac_io_status", v, 8'h81);
        load_x(8'h6D); load_ac(8'h00); read_src(AC_X, v);
        chk("ac_from_x", v, 8'h6D);
        chk("dbg_x", dbg_x, 8'h6D);
        load_ac(8'h9A);
        ac_src = AC_ZERO; ac_load = 1'b1; nz_load = 1'b1; tick();
        chk("ac_zero", dbg_ac, 0);
        chk("nz_zero", {flag_n, flag_z}, 2'b01);
        load_ac(8'hFF); set_c(8'hFF, 1'b0);
        alu_op = ALU_ADD; bus.mem_rdata = 8'h01; ac_src = AC_ALU; nz_load = 1'b1; tick();
        chk("nz_only_flags", {flag_n, flag_z, flag_c}, 3'b010);
        chk("nz_only_ac_hold", dbg_ac, 8'hFF);
        alu_op = ALU_ADD; bus.mem_rdata = 8'h01; c_load = 1'b1; tick();
        chk("c_only_flags", {flag_n, flag_z, flag_c}, 3'b011);

`ifdef NEANDER_XP_MUL_EN
        // FF x FF: eight busy cycles, a start during busy is ignored
        load_ac(8'hFF); bus.mem_rdata = 8'hFF; mul_start = 1'b1; tick();
        chk("mul_first_busy", {mul_busy, mul_done}, 2'b10);
        for (int i = 1; i < DW; i++) begin
            if (i == 3) begin bus.mem_rdata = 8'h02; mul_start = 1'b1; end
            tick();
            chk($sformatf("mul_busy_c%0d", i), {mul_busy, mul_done}, 2'b10);
        end
        tick();
        chk("mul_done_pulse", {mul_busy, mul_done}, 2'b01);
        tick();
        chk("mul_done_clear", {mul_busy, mul_done}, 2'b00);
        read_src(AC_MUL_LO, v);
        chk("mul_lo_ff", v, 8'h01);
        read_src(AC_MUL_HI, v);
        chk("mul_hi_ff", v, 8'hFE);

        // Old product is visible until the new one completes
        load_ac(8'h03); bus.mem_rdata = 8'h05; mul_start = 1'b1; tick();
        tick();
        read_src(AC_MUL_LO, v);
        chk("mul_prev_product", v, 8'h01);
        wait_done(ok);
        chk("mul_wait_done", ok, 1'b1);
        read_src(AC_MUL_LO, v);
        chk("mul_lo_15", v, 8'h0F);
        read_src(AC_MUL_HI, v);
        chk("mul_hi_15", v, 8'h00);

        // Randomized products
        for (int i = 0; i < 6; i++) begin
            a = int'($urandom_range(0, MODV - 1));
            b = int'($urandom_range(0, MODV - 1));
            load_ac(DW'(a)); bus.mem_rdata = DW'(b); mul_start = 1'b1; tick();
            wait_done(ok);
            chk($sformatf("rnd_mul%0d_done", i), ok, 1'b1);
            read_src(AC_MUL_LO, v);
            chk($sformatf("rnd_mul%0d_lo", i), v, (a * b) % MODV);
            read_src(AC_MUL_HI, v);
            chk($sformatf("rnd_mul%0d_hi", i), v, (a * b) / MODV);
        end

        // Reset mid-multiply aborts and clears the product
        load_ac(8'hFF); bus.mem_rdata = 8'hFF; mul_start = 1'b1; tick();
        repeat (3) tick();
        reset = 1'b1; #1;
        chk("mul_reset_busy", {mul_busy, mul_done}, 2'b00);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("mul_reset_sp", dbg_sp, 8'hF0);
        repeat (DW + 2) tick();
        chk("mul_reset_no_done", {mul_busy, mul_done}, 2'b00);
        load_ac(8'h55); read_src(AC_MUL_LO, v);
        chk("mul_reset_lo", v, 8'h00);
        load_ac(8'h55); read_src(AC_MUL_HI, v);
        chk("mul_reset_hi", v, 8'h00);
`else
        // No multiplier: done follows start by one cycle, product reads zero
        for (int i = 0; i < 3; i++) begin
            load_ac(8'h7E); bus.mem_rdata = 8'h03; mul_start = 1'b1; tick();
            chk($sformatf("nomul%0d_done", i), {mul_busy, mul_done}, 2'b01);
            tick();
            chk($sformatf("nomul%0d_clear", i), {mul_busy, mul_done}, 2'b00);
            read_src(AC_MUL_LO, v);
            chk($sformatf("nomul%0d_lo", i), v, 8'h00);
            load_ac(8'h7E); read_src(AC_MUL_HI, v);
            chk($sformatf("nomul%0d_hi", i), v, 8'h00);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/neander_xp_datapath.md
# neander_xp_datapath

Parametrised next-generation NEANDER-X datapath: register file (PC, REM, RDM, RI, AC, X, SP), ALU with carry, NZC flags, stack addressing, indexed addressing, a latched I/O output port and an optional iterative multiplier. It sits between the control unit and the external RAM/I/O. All source and operation selection is supplied by the control unit; this block does no opcode decoding.

## Interface
- DATA_W, 8: data/AC/RDM/RI/X width, ≥4.
- ADDR_W, 8: PC/REM/SP width, ≤ DATA_W.
- STACK_TOP, all-ones (ADDR_W): SP reset value.
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-high.
- pc_inc, pc_load, ac_load, x_load, ri_load, rem_load, rdm_load, nz_load, c_load, sp_inc, sp_dec, io_write  in  1 each  register strobes.
- addr_sel  in  2  REM source: 0 PC, 1 RDM, 2 SP, 3 RDM+X.
- wdata_sel  in  1  mem_wdata: 0 AC, 1 PC zero-extended.
- ac_src  in  3  AC source: 0 ALU, 1 mem_rdata, 2 io_in, 3 io_status, 4 X, 5 MUL_LO, 6 MUL_HI, 7 zero.
- alu_op  in  3  0 ADD, 1 AND, 2 OR, 3 NOT, 4 SUB, 5 SHL, 6 SHR, 7 PASSB.
- mul_start  in  1  start multiply AC×mem_rdata.
- mem_rdata, io_in, io_status  in  DATA_W each.
- mem_addr  out  ADDR_W  = REM.
- mem_wdata  out  DATA_W  per wdata_sel.
- io_out  out  DATA_W  latched port.
- opcode  out  4  RI[DATA_W-1 -: 4].
- flag_n, flag_z, flag_c  out  1 each.
- mul_busy, mul_done  out  1 each.
- dbg_pc, dbg_sp (ADDR_W), dbg_ac, dbg_x (DATA_W)  out.

## Operation
- PC: pc_load (from RDM[ADDR_W-1:0]) beats pc_inc; wraps modulo 2^ADDR_W.
- RDM loads mem_rdata on rdm_load; RI loads RDM on ri_load; X loads AC on x_load.
- REM source 3: (RDM+X) truncated to ADDR_W, wraps.
- SP: sp_dec → SP−1, sp_inc → SP+1, both asserted → unchanged; wraps both ways. REM sampling SP in the same cycle sees the pre-update value.
- ALU: a=AC, b=mem_rdata. ADD: C=carry-out. SUB: a−b, C=borrow. SHL: C=old MSB. SHR logical: C=old LSB. AND/OR/NOT/PASSB: C result = current C.
- Flags: nz_load samples N=ac_in MSB, Z=(ac_in==0) from the AC input mux; c_load samples ALU carry. Independent strobes.
- io_out loads AC on io_write; holds otherwise.
- Multiplier: unsigned shift-add, one bit per cycle. Operands sampled at mul_start. Product (2·DATA_W) committed to MUL_HI:MUL_LO only on completion; reading before completion returns previous product. mul_start while busy ignored.

## Timing
- All state updates on posedge clk; all outputs registered or combinational from registers/strobes.
- Reset: PC, REM, RDM, RI, AC, X, io_out, product, flags = 0; SP = STACK_TOP; mul_busy = mul_done = 0. Reset mid-multiply aborts; product = 0.
- Multiply: mul_start at edge k → mul_busy high from k through k+DATA_W−1; mul_done one-cycle pulse in cycle after edge k+DATA_W, product valid from then on; mul_busy low with mul_done. mul_start during the done cycle starts a new operation.
- AC load, flag load, REM load: single cycle.

## Configuration
- NEANDER_XP_MUL_EN defined: multiplier present as above.
- Undefined: no multiplier logic; mul_busy = 0; mul_done pulses one cycle after mul_start; MUL_LO/MUL_HI read 0. Control unit never stalls.

## Structure
- Package neander_xp_pkg: alu_op_e, ac_src_e, addr_sel_e enums and their widths.
- Sub-module neander_xp_mul (DATA_W param; start/busy/done/a/b/product), instantiated under NEANDER_XP_MUL_EN.
- ALU inline in the datapath.

## Test plan
- Reset with STACK_TOP=8'hF0 → SP=F0, all other outputs 0, flags 0.
- AC=8'hF0, mem_rdata=8'h20, ADD, ac_load+nz_load+c_load → AC=10, N=0, Z=0, C=1; SUB 10−20 → AC=F0, N=1, C=1.
- SP=00, sp_dec → FF; sp_inc+sp_dec together → unchanged; addr_sel=2 with sp_dec → REM=old SP.
- X=8'h05, RDM=8'hFE, addr_sel=3, rem_load → mem_addr=03.
- MUL_EN: AC=8'hFF, mem_rdata=8'hFF, mul_start → busy 8 cycles, done pulse, MUL_HI=FE, MUL_LO=01; mul_start during busy ignored; reset at cycle 4 → busy 0, product 0.
- MUL_EN undefined: mul_start → mul_done next cycle, MUL_LO=00.
